// File: rtl/arm_pkg.sv
// Definitions shared between the ARM pipeline decoder and the MEM-stage SRAM controller.
package arm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } sram_state_e;

  localparam int unsigned BASE_ADDR = 1024;

  // Loads and stores both use the ALU in add mode to form the byte address.
  localparam logic [3:0] ALU_LDR = 4'b0010;
  localparam logic [3:0] ALU_STR = 4'b0010;

endpackage

// File: rtl/sram_tristate_buf.sv
// Bidirectional pad driver for the SRAM data bus: drives dout while oe is high.
module sram_tristate_buf #(
  parameter int DATA_W = 16
) (
  inout  wire  [DATA_W-1:0] dq,
  input  logic              oe,
  input  logic [DATA_W-1:0] dout,
  output logic [DATA_W-1:0] din
);

  assign dq  = oe ? dout : {DATA_W{1'bz}};
  assign din = dq;

endmodule

// File: rtl/mem_sram_ctrl.sv
// MEM-stage controller: turns a one-cycle LDR/STR request into two timed half-word
// accesses on a 16-bit asynchronous SRAM, freezing the pipeline until the word is done.
module mem_sram_ctrl #(
  parameter int          DATA_W      = 32,
  parameter int          SRAM_ADDR_W = 18,
  parameter int          SRAM_DATA_W = 16,
  parameter int unsigned BASE_ADDR   = arm_pkg::BASE_ADDR,
  parameter int          WAIT_CYCLES = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   MEM_R_EN,
  input  logic                   MEM_W_EN,
  input  logic [DATA_W-1:0]      address,
  input  logic [DATA_W-1:0]      wdata,
  output logic [DATA_W-1:0]      rdata,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_OE_N,
  output logic                   SRAM_CE_N
);
  import arm_pkg::*;

  localparam int CNT_W = $clog2(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_WE_END = CNT_W'(WAIT_CYCLES - 2);

  sram_state_e            state;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_nxt;
  logic                   op_rd;
  logic [SRAM_ADDR_W-1:0] addr_lo;
  logic [DATA_W-1:0]      wdata_lat;
  logic                   dq_oe;
  logic [SRAM_DATA_W-1:0] dq_out;
  logic [SRAM_DATA_W-1:0] dq_din;

  // Low half-word address of the word; addresses under BASE_ADDR wrap silently.
  function automatic logic [SRAM_ADDR_W-1:0] half_lo(input logic [DATA_W-1:0] a);
    return SRAM_ADDR_W'(((a - DATA_W'(BASE_ADDR)) >> 2) << 1);
  endfunction

  assign cnt_nxt = cnt + CNT_W'(1);
  assign ready   = (state == IDLE) ? ~(MEM_R_EN | MEM_W_EN) : (state == DONE);

  sram_tristate_buf #(.DATA_W(SRAM_DATA_W)) u_dq_buf (
    .dq   (SRAM_DQ),
    .oe   (dq_oe),
    .dout (dq_out),
    .din  (dq_din)
  );

  // Strobes are registered and set up on the edge entering each phase, so the
  // address is already stable on the first cycle of LO/HI.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      op_rd     <= 1'b0;
      addr_lo   <= '0;
      wdata_lat <= '0;
      rdata     <= '0;
      SRAM_ADDR <= '0;
      SRAM_WE_N <= 1'b1;
      SRAM_OE_N <= 1'b1;
      SRAM_CE_N <= 1'b1;
      dq_oe     <= 1'b0;
      dq_out    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (MEM_R_EN | MEM_W_EN) begin
            state     <= LO;
            cnt       <= '0;
            op_rd     <= MEM_R_EN;
            addr_lo   <= half_lo(address);
            wdata_lat <= wdata;
            SRAM_ADDR <= half_lo(address);
            SRAM_CE_N <= 1'b0;
            SRAM_OE_N <= ~MEM_R_EN;
            SRAM_WE_N <= 1'b1;
            dq_oe     <= ~MEM_R_EN;
            dq_out    <= wdata[SRAM_DATA_W-1:0];
          end
        end
        LO, HI: begin
          if (cnt == CNT_LAST) begin
            cnt       <= '0;
            SRAM_WE_N <= 1'b1;
            if (op_rd) begin
              if (state == LO) rdata[SRAM_DATA_W-1:0]      <= dq_din;
              else             rdata[DATA_W-1:SRAM_DATA_W] <= dq_din;
            end
            if (state == LO) begin
              state     <= HI;
              SRAM_ADDR <= {addr_lo[SRAM_ADDR_W-1:1], 1'b1};
              dq_out    <= wdata_lat[DATA_W-1:SRAM_DATA_W];
            end else begin
              state     <= DONE;
              SRAM_CE_N <= 1'b1;
              SRAM_OE_N <= 1'b1;
              dq_oe     <= 1'b0;
            end
          end else begin
            cnt       <= cnt_nxt;
            // First and last cycles of a write phase keep WE_N high for setup/hold.
            SRAM_WE_N <= op_rd | (cnt_nxt > CNT_WE_END);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Directed bench for mem_sram_ctrl with a behavioural 1-cycle SRAM and a read scoreboard.
module tb_mem_sram_ctrl;

  localparam int WAIT = 5;
  localparam int LAT  = 1 + 2 * WAIT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MEM_R_EN = 1'b0;
  logic        MEM_W_EN = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ready;
  logic [17:0] SRAM_ADDR;
  wire  [15:0] sram_dq;
  logic        SRAM_WE_N, SRAM_OE_N, SRAM_CE_N;

  int vecs = 0;
  int miss = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rd = '0;

  logic [15:0] mem [256];
  logic [15:0] mem_q;
  logic        model_drv;

  always #5 clk = ~clk;

  mem_sram_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .MEM_R_EN  (MEM_R_EN),
    .MEM_W_EN  (MEM_W_EN),
    .address   (address),
    .wdata     (wdata),
    .rdata     (rdata),
    .ready     (ready),
    .SRAM_ADDR (SRAM_ADDR),
    .SRAM_DQ   (sram_dq),
    .SRAM_WE_N (SRAM_WE_N),
    .SRAM_OE_N (SRAM_OE_N),
    .SRAM_CE_N (SRAM_CE_N)
  );

  // SRAM model: registered read data (one-cycle access), write on clock while WE_N low.
  assign model_drv = !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N;
  assign sram_dq   = model_drv ? mem_q : 16'hzzzz;

  always @(posedge clk) begin
    mem_q <= mem[SRAM_ADDR[7:0]];
    if (!SRAM_CE_N && !SRAM_WE_N) mem[SRAM_ADDR[7:0]] <= sram_dq;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] exp_lo(input logic [31:0] a);
    logic [31:0] word;
    word = (a - 32'd1024) / 4;
    return 18'((word * 2) % (1 << 18));
  endfunction

  // Issue one request; lead=1 when it is presented during the previous DONE cycle.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input int lead, input logic [31:0] exp_rd);
    int c;
    int cn;
    logic [17:0] lo;
    lo = exp_lo(a);
    MEM_R_EN = rd;
    MEM_W_EN = wr;
    address  = a;
    wdata    = d;
    if (rd) exp_q.push_back(exp_rd);
    repeat (lead) @(negedge clk);
    #1;
    chk("req_ready_low", 32'(ready), 32'd0);
    chk("req_ce_idle", 32'(SRAM_CE_N), 32'd1);
    c = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      c = k;
      if (ready) break;
      cn = (k - 1) % WAIT;
      chk("ce_active", 32'(SRAM_CE_N), 32'd0);
      chk("sram_addr", 32'(SRAM_ADDR), (k <= WAIT) ? 32'(lo) : 32'(lo | 18'd1));
      if (rd) begin
        chk("rd_oe_n", 32'(SRAM_OE_N), 32'd0);
        chk("rd_we_n", 32'(SRAM_WE_N), 32'd1);
        chk("rd_dq_released", 32'(dut.dq_oe), 32'd0);
      end else begin
        chk("wr_oe_n", 32'(SRAM_OE_N), 32'd1);
        chk("wr_we_n", 32'(SRAM_WE_N), (cn >= 1 && cn <= WAIT - 2) ? 32'd0 : 32'd1);
        chk("wr_dq", 32'(sram_dq), (k <= WAIT) ? 32'(d[15:0]) : 32'(d[31:16]));
      end
    end
    chk("latency", 32'(c), 32'(LAT));
    chk("done_strobes", {29'd0, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N}, 32'd7);
    chk("done_dq_released", 32'(dut.dq_oe), 32'd0);
    if (rd) begin
      if (exp_q.size() > 0) chk("rdata", rdata, exp_q.pop_front());
      else chk("scoreboard_empty", 32'(exp_q.size()), 32'd1);
      last_rd = exp_rd;
    end else begin
      chk("wr_rdata_kept", rdata, last_rd);
    end
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'hA5A5;

    // Reset
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_strobes", {29'd0, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N}, 32'd7);
    chk("rst_addr", 32'(SRAM_ADDR), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_dq_released", 32'(dut.dq_oe), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(ready), 32'd1);
    chk("post_rst_ce", 32'(SRAM_CE_N), 32'd1);

    // Store then load at the base address
    do_access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 0, 32'd0);
    @(negedge clk);
    chk("mem0", 32'(mem[0]), 32'h0000BEEF);
    chk("mem1", 32'(mem[1]), 32'h0000DEAD);
    @(negedge clk);
    do_access(1'b1, 1'b0, 32'd1024, 32'd0, 0, 32'hDEADBEEF);
    @(negedge clk);

    // Back-to-back store/load at 1028 (half-words 2 and 3)
    do_access(1'b0, 1'b1, 32'd1028, 32'hCAFEF00D, 0, 32'd0);
    do_access(1'b1, 1'b0, 32'd1028, 32'd0, 1, 32'hCAFEF00D);
    chk("mem2", 32'(mem[2]), 32'h0000F00D);
    chk("mem3", 32'(mem[3]), 32'h0000CAFE);
    @(negedge clk);

    // Address below the base wraps to the top of the SRAM
    do_access(1'b0, 1'b1, 32'd1020, 32'h12345678, 0, 32'd0);
    do_access(1'b1, 1'b0, 32'd1020, 32'd0, 1, 32'h12345678);
    @(negedge clk);

    // Both enables: read wins and memory is untouched
    do_access(1'b1, 1'b1, 32'd1024, 32'h0BADF00D, 0, 32'hDEADBEEF);
    chk("conflict_mem0", 32'(mem[0]), 32'h0000BEEF);
    @(negedge clk);

    // No request: stays idle
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("noop_ready", 32'(ready), 32'd1);
      chk("noop_ce", 32'(SRAM_CE_N), 32'd1);
    end

    // Reset in the middle of a LO-phase write
    MEM_W_EN = 1'b1;
    address  = 32'd1032;
    wdata    = 32'h55667788;
    repeat (4) @(negedge clk);
    chk("midop_we_low", 32'(SRAM_WE_N), 32'd0);
    rst_n    = 1'b0;
    MEM_W_EN = 1'b0;
    #1;
    chk("midop_we_n", 32'(SRAM_WE_N), 32'd1);
    chk("midop_ce_n", 32'(SRAM_CE_N), 32'd1);
    chk("midop_dq_released", 32'(dut.dq_oe), 32'd0);
    chk("midop_state", 32'(dut.state), 32'd0);
    chk("midop_ready", 32'(ready), 32'd1);
    chk("midop_rdata", rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("midop_no_hi", 32'(SRAM_CE_N), 32'd1);
    end
    chk("midop_mem5", 32'(mem[5]), 32'h0000A5A5);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation timeout");
  end

endmodule
